// File: rtl/divider_restoring_seq.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per cycle.
// Optional macro DIV_OVF_DETECT_EN enables early overflow / divide-by-zero detection.
module divider_restoring_seq #(
   parameter int N = 28
) (
   input  logic           clk,
   input  logic           rstn,
   input  logic           start,
   input  logic [2*N-1:0] dividend,
   input  logic [N-1:0]   divisor,
   output logic           busy,
   output logic           done,
   output logic [N-1:0]   quot,
   output logic [N-1:0]   rem,
   output logic           ovf
);

   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [N:0]    prem_q, prem_d;
   logic [N-1:0]  shreg_q, shreg_d;
   logic [N-1:0]  dvs_q, dvs_d;
   logic [N-1:0]  quot_q, quot_d;
   logic [N-1:0]  rem_q, rem_d;
`ifdef DIV_OVF_DETECT_EN
   logic          ovf_q, ovf_d;
`endif

   logic [N:0]    shifted;
   logic [N+1:0]  diff;
   logic [N:0]    step_rem;
   logic [N-1:0]  step_sh;

   // One restoring step: shift in the next dividend bit and trial-subtract the divisor.
   always_comb begin
      shifted = {prem_q[N-1:0], shreg_q[N-1]};
      diff    = {1'b0, shifted} - {2'b00, dvs_q};
      if (!diff[N+1]) begin
         step_rem = diff[N:0];
         step_sh  = {shreg_q[N-2:0], 1'b1};
      end else begin
         step_rem = shifted;
         step_sh  = {shreg_q[N-2:0], 1'b0};
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      prem_d  = prem_q;
      shreg_d = shreg_q;
      dvs_d   = dvs_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
`ifdef DIV_OVF_DETECT_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               dvs_d   = divisor;
               prem_d  = {1'b0, dividend[2*N-1:N]};
               shreg_d = dividend[N-1:0];
               cnt_d   = '0;
               state_d = RUN;
`ifdef DIV_OVF_DETECT_EN
               // Quotient would not fit in N bits (or divisor is zero): skip RUN.
               if (dividend[2*N-1:N] >= divisor) begin
                  state_d = DONE;
                  quot_d  = '1;
                  rem_d   = '0;
                  ovf_d   = 1'b1;
               end
`endif
            end
         end
         RUN: begin
            prem_d  = step_rem;
            shreg_d = step_sh;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CW'(N - 1)) begin
               state_d = DONE;
               quot_d  = step_sh;
               rem_d   = step_rem[N-1:0];
`ifdef DIV_OVF_DETECT_EN
               ovf_d   = 1'b0;
`endif
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         prem_q  <= '0;
         shreg_q <= '0;
         dvs_q   <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
`ifdef DIV_OVF_DETECT_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         prem_q  <= prem_d;
         shreg_q <= shreg_d;
         dvs_q   <= dvs_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
`ifdef DIV_OVF_DETECT_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);
   assign quot = quot_q;
   assign rem  = rem_q;
`ifdef DIV_OVF_DETECT_EN
   assign ovf  = ovf_q;
`else
   assign ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_divider_restoring_seq.sv
// Self-checking bench for divider_restoring_seq: vector table plus hand-written multi-cycle sequences.
// Overflow checks depend on DIV_OVF_DETECT_EN matching the RTL build.
module tb_divider_restoring_seq;

   localparam int N = 28;

   logic           clk;
   logic           rstn;
   logic           start;
   logic [2*N-1:0] dividend;
   logic [N-1:0]   divisor;
   logic           busy;
   logic           done;
   logic [N-1:0]   quot;
   logic [N-1:0]   rem;
   logic           ovf;

   int pass_cnt;
   int total_cnt;

   typedef struct {
      logic [2*N-1:0] dd;
      logic [N-1:0]   dv;
      logic [N-1:0]   q;
      logic [N-1:0]   r;
   } vec_t;

   vec_t vecs[9];

   divider_restoring_seq #(.N(N)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .start    (start),
      .dividend (dividend),
      .divisor  (divisor),
      .busy     (busy),
      .done     (done),
      .quot     (quot),
      .rem      (rem),
      .ovf      (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Starts one division and returns edges-to-done (start edge = 0) and the busy cycle count.
   task automatic applyStimulus(input logic [2*N-1:0] dd, input logic [N-1:0] dv,
                                output int lat, output int bcnt);
      @(negedge clk);
      dividend = dd;
      divisor  = dv;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      lat   = -1;
      bcnt  = 0;
      for (int e = 0; e <= 100; e++) begin
         if (done) begin
            lat = e;
            break;
         end
         if (busy) bcnt++;
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int lat, bcnt, ndone, first_q, first_r;
      int pulse_edge[$];
      logic [N-1:0] pulse_q[$];
      logic [N-1:0] pulse_r[$];

      pass_cnt  = 0;
      total_cnt = 0;

      vecs[0] = '{56'd100,               28'd7,          28'd14,          28'd2};
      vecs[1] = '{56'd1000,              28'd33,         28'd30,          28'd10};
      vecs[2] = '{56'hFFFFFFE0000001,    28'hFFFFFFF,    28'hFFFFFFF,     28'd0};
      vecs[3] = '{56'd200,               28'd9,          28'd22,          28'd2};
      vecs[4] = '{56'd0,                 28'd5,          28'd0,           28'd0};
      vecs[5] = '{56'd12345,             28'd1,          28'd12345,       28'd0};
      vecs[6] = '{56'h0000000FFFFFFF,    28'h8000000,    28'd1,           28'h7FFFFFF};
      vecs[7] = '{56'h00000010000000,    28'd2,          28'h8000000,     28'd0};
      vecs[8] = '{56'd6,                 28'd7,          28'd0,           28'd6};

      rstn     = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (2) @(negedge clk);
      checkOutput("reset_busy", 64'(busy), 64'd0);
      checkOutput("reset_done", 64'(done), 64'd0);
      checkOutput("reset_quot", 64'(quot), 64'd0);
      checkOutput("reset_rem",  64'(rem),  64'd0);
      checkOutput("reset_ovf",  64'(ovf),  64'd0);
      rstn = 1'b1;

      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i].dd, vecs[i].dv, lat, bcnt);
         checkOutput($sformatf("vec%0d_latency", i), 64'(lat),  64'd28);
         checkOutput($sformatf("vec%0d_busy",    i), 64'(bcnt), 64'd28);
         checkOutput($sformatf("vec%0d_quot",    i), 64'(quot), 64'(vecs[i].q));
         checkOutput($sformatf("vec%0d_rem",     i), 64'(rem),  64'(vecs[i].r));
         checkOutput($sformatf("vec%0d_ovf",     i), 64'(ovf),  64'd0);
         @(posedge clk);
         #1;
         checkOutput($sformatf("vec%0d_done_pulse", i), 64'(done), 64'd0);
         repeat (3) @(posedge clk);
         #1;
         checkOutput($sformatf("vec%0d_hold_quot", i), 64'(quot), 64'(vecs[i].q));
      end

      // Second start mid-run must be ignored; results of the previous op hold until the new done.
      @(negedge clk);
      dividend = 56'd100;
      divisor  = 28'd7;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      checkOutput("ign_busy_mid", 64'(busy), 64'd1);
      checkOutput("ign_hold_quot", 64'(quot), 64'd0);
      checkOutput("ign_hold_rem",  64'(rem),  64'd6);
      dividend = 56'd200;
      divisor  = 28'd9;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start   = 1'b0;
      ndone   = 0;
      first_q = 0;
      first_r = 0;
      for (int e = 0; e < 40; e++) begin
         if (done) begin
            ndone++;
            if (ndone == 1) begin
               first_q = int'(quot);
               first_r = int'(rem);
            end
         end
         @(posedge clk);
         #1;
      end
      checkOutput("ign_done_count", 64'(ndone),   64'd1);
      checkOutput("ign_quot",       64'(first_q), 64'd14);
      checkOutput("ign_rem",        64'(first_r), 64'd2);

      // Reset in the middle of a run aborts it and clears everything.
      @(negedge clk);
      dividend = 56'd100;
      divisor  = 28'd7;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rstn = 1'b0;
      #1;
      checkOutput("abort_busy", 64'(busy), 64'd0);
      checkOutput("abort_done", 64'(done), 64'd0);
      checkOutput("abort_quot", 64'(quot), 64'd0);
      checkOutput("abort_rem",  64'(rem),  64'd0);
      checkOutput("abort_ovf",  64'(ovf),  64'd0);
      ndone = 0;
      repeat (2) begin
         @(negedge clk);
         if (done) ndone++;
      end
      rstn = 1'b1;
      for (int e = 0; e < 30; e++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      checkOutput("abort_no_done", 64'(ndone), 64'd0);
      applyStimulus(56'd1000, 28'd33, lat, bcnt);
      checkOutput("after_abort_latency", 64'(lat),  64'd28);
      checkOutput("after_abort_quot",    64'(quot), 64'd30);
      checkOutput("after_abort_rem",     64'(rem),  64'd10);

      // Start held high: back-to-back operations every N+2 cycles.
      @(negedge clk);
      dividend = 56'd100;
      divisor  = 28'd7;
      start    = 1'b1;
      for (int e = 0; e < 100; e++) begin
         @(posedge clk);
         #1;
         if (done) begin
            pulse_edge.push_back(e);
            pulse_q.push_back(quot);
            pulse_r.push_back(rem);
         end
      end
      start = 1'b0;
      checkOutput("held_pulse_count", 64'(pulse_edge.size()), 64'd3);
      for (int k = 0; k < pulse_edge.size(); k++) begin
         checkOutput($sformatf("held_quot%0d", k), 64'(pulse_q[k]), 64'd14);
         checkOutput($sformatf("held_rem%0d",  k), 64'(pulse_r[k]), 64'd2);
         if (k > 0)
            checkOutput($sformatf("held_period%0d", k),
                        64'(pulse_edge[k] - pulse_edge[k-1]), 64'd30);
      end
      @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;

`ifdef DIV_OVF_DETECT_EN
      applyStimulus(56'd100, 28'd0, lat, bcnt);
      checkOutput("ovf_dz_latency", 64'(lat),  64'd0);
      checkOutput("ovf_dz_busy",    64'(bcnt), 64'd0);
      checkOutput("ovf_dz_flag",    64'(ovf),  64'd1);
      checkOutput("ovf_dz_quot",    64'(quot), 64'hFFFFFFF);
      checkOutput("ovf_dz_rem",     64'(rem),  64'd0);
      applyStimulus(56'h00000070000000, 28'd7, lat, bcnt);
      checkOutput("ovf_big_latency", 64'(lat),  64'd0);
      checkOutput("ovf_big_busy",    64'(bcnt), 64'd0);
      checkOutput("ovf_big_flag",    64'(ovf),  64'd1);
      checkOutput("ovf_big_quot",    64'(quot), 64'hFFFFFFF);
      checkOutput("ovf_big_rem",     64'(rem),  64'd0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("ovf_hold_flag", 64'(ovf), 64'd1);
      applyStimulus(56'd100, 28'd7, lat, bcnt);
      checkOutput("ovf_clear_flag", 64'(ovf),  64'd0);
      checkOutput("ovf_clear_quot", 64'(quot), 64'd14);
`else
      applyStimulus(56'd100, 28'd0, lat, bcnt);
      checkOutput("dz_latency", 64'(lat),  64'd28);
      checkOutput("dz_busy",    64'(bcnt), 64'd28);
      checkOutput("dz_ovf",     64'(ovf),  64'd0);
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
